seq_rotator: RTL and testbench

//   Multi-cycle rotate unit for the datapath ALU. Rotates operand B by A mod 32 bit positions,

---
 rtl/seq_rotator.sv | 64 ++++++
 tb/tb_seq_rotator.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_rotator.sv
// seq_rotator: multi-cycle rotate of B by A mod 32, one bit per clock, taking the shorter direction.
module seq_rotator #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   n_amt, eff;
    logic               long_way, accept;
    logic               unused_a;
    assign unused_a = ^A[WIDTH-1:CNT_W];
    assign n_amt    = A[CNT_W-1:0];
    assign long_way = n_amt > CNT_W'(16);
    // Two's complement negation of N yields 32-N within the counter width.
    assign eff      = long_way ? CNT_W'(0) - n_amt : n_amt;
    assign accept   = start && (state_q != RUN);
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (accept) begin
            r_d     = B;
            cnt_d   = eff;
            dir_d   = dir ^ long_way;
            state_d = (eff != '0) ? RUN : DONE;
        end else if (state_q == RUN) begin
            r_d     = dir_q ? {r_q[0], r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign R    = r_q;
endmodule

// File: tb/tb_seq_rotator.sv
// tb_seq_rotator: directed and randomized checks of seq_rotator against an arithmetic rotate model.
module tb_seq_rotator;
    logic        clock = 1'b0;
    logic        reset, start, dir;
    logic [31:0] B, A;
    logic        busy, done;
    logic [31:0] R;
    int          n_checks = 0;
    int          n_pass   = 0;

    seq_rotator dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir),
        .B(B), .A(A), .busy(busy), .done(done), .R(R)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Requested rotation done the long way if need be; the DUT's shortcut must agree.
    function automatic logic [31:0] ref_rot(input logic [31:0] b, input logic [31:0] a, input logic d);
        int n = int'(a % 32);
        if (n == 0) return b;
        return d ? ((b >> n) | (b << (32 - n))) : ((b << n) | (b >> (32 - n)));
    endfunction

    function automatic int ref_steps(input logic [31:0] a);
        int n = int'(a % 32);
        return (n > 16) ? 32 - n : n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full operation; poke > 0 raises start with junk operands at that RUN cycle.
    task automatic run_op(input string tag, input logic [31:0] b, input logic [31:0] a,
                          input logic d, input int poke);
        logic [31:0] exp  = ref_rot(b, a, d);
        int          exp_c = ref_steps(a);
        int          cycles = 0;
        int          guard  = 0;
        B = b; A = a; dir = d; start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && guard < 40) begin
            if (busy) cycles++;
            start = (poke > 0) && (cycles == poke);
            if (start) begin
                B = 32'hFFFF_FFFF; A = $urandom; dir = 1'($urandom);
            end
            tick();
            guard++;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " run_cycles"}, 32'(cycles), 32'(exp_c));
        check({tag, " R"}, R, exp);
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " R_hold"}, R, exp);
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; dir = 1'b0; B = '0; A = '0;
        tick(); tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset R", R, 32'd0);
        reset = 1'b0;
        tick();

        run_op("t1", 32'h8000_0001, 32'd1, 1'b0, 0);
        check("t1 value", R, 32'h0000_0003);
        run_op("t2r", 32'h1234_5678, 32'd4, 1'b1, 0);
        check("t2r value", R, 32'h8123_4567);
        run_op("t2l", 32'h1234_5678, 32'd28, 1'b0, 0);
        check("t2l value", R, 32'h8123_4567);
        run_op("t3a32", 32'hDEAD_BEEF, 32'd32, 1'b1, 0);
        run_op("t3a0", 32'hDEAD_BEEF, 32'd0, 1'b1, 0);
        run_op("t3a16", 32'hDEAD_BEEF, 32'd16, 1'b0, 0);
        check("t3a16 value", R, 32'hBEEF_DEAD);
        run_op("t4", 32'h0000_0001, 32'd37, 1'b0, 2);
        check("t4 value", R, 32'h0000_0020);

        // Reset during RUN abandons the operation without a done pulse.
        B = 32'h1234_5678; A = 32'd8; dir = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 done", 32'(done), 32'd0);
        check("t5 R", R, 32'd0);
        tick();
        check("t5 no_done", 32'(done), 32'd0);
        run_op("t5 after", 32'h1234_5678, 32'd8, 1'b0, 0);

        // Back-to-back: start held through DONE re-accepts with no idle bubble.
        B = 32'h0000_000F; A = 32'd4; dir = 1'b1; start = 1'b1;
        tick();
        guard = 0;
        while (!done && guard < 40) begin tick(); guard++; end
        check("t6 first done", 32'(done), 32'd1);
        check("t6 first R", R, 32'hF000_0000);
        tick();
        start = 1'b0;
        check("t6 second busy", 32'(busy), 32'd1);
        check("t6 second R_start", R, 32'h0000_000F);
        guard = 0;
        while (!done && guard < 40) begin tick(); guard++; end
        check("t6 second done", 32'(done), 32'd1);
        check("t6 second R", R, 32'hF000_0000);
        tick();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rb = $urandom;
            logic [31:0] ra = $urandom;
            logic        rd = 1'($urandom);
            int          st = ref_steps(ra);
            int          pk = (st > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(st, 1)) : 0;
            run_op($sformatf("rnd%0d", i), rb, ra, rd, pk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
